// File: rtl/drive_cmd_arbiter.sv
// Two-requester arbiter for the car-simulator UART command byte: fixed M priority,
// minimum dwell per latched command, and a stop-byte gap on every ownership change.
module drive_cmd_arbiter #(
  parameter int unsigned HOLD_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES  = 10
) (
  input  logic       i_sys_clk,
  input  logic       i_rst,
  input  logic       i_req_m,
  input  logic [5:0] i_cmd_m,
  input  logic       i_req_a,
  input  logic [5:0] i_cmd_a,
  output logic [7:0] o_data_out,
  output logic       o_gnt_m,
  output logic       o_gnt_a,
  output logic       o_dwell_done,
  output logic       o_cmd_err,
  output logic [1:0] o_arb_state
);

  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [7:0]      StopByte = 8'h80;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGntM = 2'b01,
    StGntA = 2'b10,
    StGap  = 2'b11
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [7:0]      r_data_out;
  logic            r_gnt_m;
  logic            r_gnt_a;
  logic            r_dwell_done;
  logic            r_cmd_err;

  logic [5:0] w_san_m;
  logic [5:0] w_san_a;
  logic       w_err_m;
  logic       w_err_a;

  // Opposing direction pairs cancel to "neither"; place/destroy pass through.
  assign w_err_m = (&i_cmd_m[1:0]) | (&i_cmd_m[3:2]);
  assign w_err_a = (&i_cmd_a[1:0]) | (&i_cmd_a[3:2]);
  assign w_san_m = {i_cmd_m[5:4], i_cmd_m[3:2] & ~{2{&i_cmd_m[3:2]}},
                    i_cmd_m[1:0] & ~{2{&i_cmd_m[1:0]}}};
  assign w_san_a = {i_cmd_a[5:4], i_cmd_a[3:2] & ~{2{&i_cmd_a[3:2]}},
                    i_cmd_a[1:0] & ~{2{&i_cmd_a[1:0]}}};

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_data_out   <= StopByte;
      r_gnt_m      <= 1'b0;
      r_gnt_a      <= 1'b0;
      r_dwell_done <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_dwell_done <= 1'b0;
      r_cmd_err    <= 1'b0;
      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (i_req_m) begin
            r_state    <= StGntM;
            r_data_out <= {2'b10, w_san_m};
            r_gnt_m    <= 1'b1;
            r_gnt_a    <= 1'b0;
            r_cmd_err  <= w_err_m;
          end else if (i_req_a) begin
            r_state    <= StGntA;
            r_data_out <= {2'b10, w_san_a};
            r_gnt_m    <= 1'b0;
            r_gnt_a    <= 1'b1;
            r_cmd_err  <= w_err_a;
          end else begin
            r_data_out <= StopByte;
            r_gnt_m    <= 1'b0;
            r_gnt_a    <= 1'b0;
          end
        end
        StGntM: begin
          if (r_cnt == HoldLast) begin
            r_dwell_done <= 1'b1;
            r_cnt        <= '0;
            if (i_req_m) begin
              r_data_out <= {2'b10, w_san_m};
              r_cmd_err  <= w_err_m;
            end else begin
              r_state    <= StGap;
              r_data_out <= StopByte;
              r_gnt_m    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StGntA: begin
          if (r_cnt == HoldLast) begin
            r_dwell_done <= 1'b1;
            r_cnt        <= '0;
            // M preempts A only at a dwell boundary, and always through a gap.
            if (!i_req_m && i_req_a) begin
              r_data_out <= {2'b10, w_san_a};
              r_cmd_err  <= w_err_a;
            end else begin
              r_state    <= StGap;
              r_data_out <= StopByte;
              r_gnt_a    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StGap: begin
          r_data_out <= StopByte;
          r_gnt_m    <= 1'b0;
          r_gnt_a    <= 1'b0;
          if (r_cnt == GapLast) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state    <= StIdle;
          r_cnt      <= '0;
          r_data_out <= StopByte;
          r_gnt_m    <= 1'b0;
          r_gnt_a    <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_out   = r_data_out;
  assign o_gnt_m      = r_gnt_m;
  assign o_gnt_a      = r_gnt_a;
  assign o_dwell_done = r_dwell_done;
  assign o_cmd_err    = r_cmd_err;
  assign o_arb_state  = r_state;

endmodule
